hazard_tag_pipeline: RTL and testbench

Tracks register tags (source/destination register numbers and write/load flags) for each instruction as it moves from ID through EX, MEM and WB. It produces the operand tags that the EX-stage forwarding logic compares. It also detects load-use and EX-busy hazards and drives the stall and bubble controls for the front of the pipeline. It sits beside the datapath pipeline registers and is the producer of every tag the forwarding unit consumes.

---
 rtl/hazard_tag_pipeline_if.sv | 41 ++++
 rtl/hazard_tag_pipeline.sv | 109 ++++++++++
 tb/tb_hazard_tag_pipeline.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_tag_pipeline_if.sv
// Tag/hazard bus between the pipeline front end and the hazard tag tracker.
// master = front end driving ID-stage tags; slave = the tracker producing tags and stalls.
interface hazard_tag_pipeline_if #(
  parameter int NREG_W = 5,
  parameter int CNT_W  = 16
);
  logic              idValid;
  logic [NREG_W-1:0] rsID;
  logic [NREG_W-1:0] rtID;
  logic              useRs;
  logic              useRt;
  logic [NREG_W-1:0] rdID;
  logic              regWriteID;
  logic              memReadID;
  logic              flushID;
  logic              exBusy;
  logic              statClear;
  logic              stall;
  logic              bubbleEX;
  logic [NREG_W-1:0] rsEX;
  logic [NREG_W-1:0] rtEX;
  logic [NREG_W-1:0] rdMEM;
  logic [NREG_W-1:0] rdWB;
  logic              regWriteMEM;
  logic              regWriteWB;
  logic [CNT_W-1:0]  stallCycles;

  modport master (
    output idValid, rsID, rtID, useRs, useRt, rdID, regWriteID, memReadID,
           flushID, exBusy, statClear,
    input  stall, bubbleEX, rsEX, rtEX, rdMEM, rdWB, regWriteMEM, regWriteWB,
           stallCycles
  );

  modport slave (
    input  idValid, rsID, rtID, useRs, useRt, rdID, regWriteID, memReadID,
           flushID, exBusy, statClear,
    output stall, bubbleEX, rsEX, rtEX, rdMEM, rdWB, regWriteMEM, regWriteWB,
           stallCycles
  );
endinterface

// File: rtl/hazard_tag_pipeline.sv
// Register-tag tracker for EX/MEM/WB: feeds forwarding tags and detects
// load-use and EX-busy hazards driving stall/bubble for the pipeline front.
module hazard_tag_pipeline #(
  parameter int NREG_W = 5,
  parameter int CNT_W  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  hazard_tag_pipeline_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] rs;
    logic [NREG_W-1:0] rt;
    logic [NREG_W-1:0] rd;
    logic              regWrite;
    logic              memRead;
  } tagRec_t;

  localparam tagRec_t BUBBLE = '{
    valid: 1'b0, rs: {NREG_W{1'b0}}, rt: {NREG_W{1'b0}}, rd: {NREG_W{1'b0}},
    regWrite: 1'b0, memRead: 1'b0
  };

  tagRec_t          exRec_r, memRec_r, wbRec_r;
  tagRec_t          exNext_s, memNext_s, wbNext_s, idRec_s;
  logic             loadUse_s;
  logic             stall_s;
  logic [CNT_W-1:0] stallCycles_r;

  // A write to $0 is never a real producer, so it is masked out here once.
  function automatic logic qualWrite(input tagRec_t rec);
    return rec.valid & rec.regWrite & (rec.rd != {NREG_W{1'b0}});
  endfunction

  // Build the ID record; anything not entering EX as a real instruction is a bubble.
  always_comb begin
    idRec_s = BUBBLE;
    if (bus.idValid && !bus.flushID) begin
      idRec_s.valid    = 1'b1;
      idRec_s.rs       = bus.rsID;
      idRec_s.rt       = bus.rtID;
      idRec_s.rd       = bus.rdID;
      idRec_s.regWrite = bus.regWriteID;
      idRec_s.memRead  = bus.memReadID;
    end else begin
      idRec_s = BUBBLE;
    end
  end

  assign loadUse_s = bus.idValid & ~bus.flushID & exRec_r.valid & exRec_r.memRead &
                     (exRec_r.rd != {NREG_W{1'b0}}) &
                     ((bus.useRs & (bus.rsID == exRec_r.rd)) |
                      (bus.useRt & (bus.rtID == exRec_r.rd)));
  assign stall_s   = loadUse_s | bus.exBusy;

  // Stage advance: a busy EX freezes itself and drains bubbles behind it.
  always_comb begin
    exNext_s  = exRec_r;
    memNext_s = exRec_r;
    wbNext_s  = memRec_r;
    if (bus.exBusy) begin
      exNext_s  = exRec_r;
      memNext_s = BUBBLE;
    end else if (loadUse_s) begin
      exNext_s  = BUBBLE;
    end else begin
      exNext_s  = idRec_s;
    end
  end

  // Stage tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exRec_r  <= BUBBLE;
      memRec_r <= BUBBLE;
      wbRec_r  <= BUBBLE;
    end else begin
      exRec_r  <= exNext_s;
      memRec_r <= memNext_s;
      wbRec_r  <= wbNext_s;
    end
  end

  // Saturating stall statistics; clear wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles_r <= {CNT_W{1'b0}};
    end else if (bus.statClear) begin
      stallCycles_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stallCycles_r != {CNT_W{1'b1}})) begin
      stallCycles_r <= stallCycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stallCycles_r <= stallCycles_r;
    end
  end

  assign bus.stall       = stall_s;
  assign bus.bubbleEX    = loadUse_s & ~bus.exBusy;
  assign bus.rsEX        = exRec_r.rs;
  assign bus.rtEX        = exRec_r.rt;
  assign bus.rdMEM       = memRec_r.rd;
  assign bus.rdWB        = wbRec_r.rd;
  assign bus.regWriteMEM = qualWrite(memRec_r);
  assign bus.regWriteWB  = qualWrite(wbRec_r);
  assign bus.stallCycles = stallCycles_r;

endmodule

// File: tb/tb_hazard_tag_pipeline.sv
// Directed, table-driven bench for hazard_tag_pipeline plus hand sequences
// for EX-busy, asynchronous reset mid-stall and counter saturation/clear.
module tb_hazard_tag_pipeline;

  localparam int NREG_W = 5;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  hazard_tag_pipeline_if #(.NREG_W(NREG_W), .CNT_W(CNT_W)) bus ();

  hazard_tag_pipeline #(.NREG_W(NREG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int iv, rs, rt, ur, ut, rd, rw, mr, fl, bz, clr;
    int eStall, eBub;
    int eRsEX, eRtEX, eRdMEM, eRdWB, eWM, eWW, eCnt;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input int iv, input int rs, input int rt, input int ur, input int ut,
                       input int rd, input int rw, input int mr, input int fl,
                       input int bz, input int clr);
    bus.idValid    = iv[0];
    bus.rsID       = rs[NREG_W-1:0];
    bus.rtID       = rt[NREG_W-1:0];
    bus.useRs      = ur[0];
    bus.useRt      = ut[0];
    bus.rdID       = rd[NREG_W-1:0];
    bus.regWriteID = rw[0];
    bus.memReadID  = mr[0];
    bus.flushID    = fl[0];
    bus.exBusy     = bz[0];
    bus.statClear  = clr[0];
  endtask

  task automatic chkRegs(input string tag, input int rsE, input int rtE, input int rdM,
                         input int rdW, input int wM, input int wW, input int cnt);
    chk({tag, ".rsEX"}, 32'(bus.rsEX), rsE);
    chk({tag, ".rtEX"}, 32'(bus.rtEX), rtE);
    chk({tag, ".rdMEM"}, 32'(bus.rdMEM), rdM);
    chk({tag, ".rdWB"}, 32'(bus.rdWB), rdW);
    chk({tag, ".regWriteMEM"}, 32'(bus.regWriteMEM), wM);
    chk({tag, ".regWriteWB"}, 32'(bus.regWriteWB), wW);
    chk({tag, ".stallCycles"}, 32'(bus.stallCycles), cnt);
  endtask

  task automatic chkComb(input string tag, input int st, input int bu);
    chk({tag, ".stall"}, 32'(bus.stall), st);
    chk({tag, ".bubbleEX"}, 32'(bus.bubbleEX), bu);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    //          iv rs rt ur ut rd rw mr fl bz clr st bu rsE rtE rdM rdW wM wW cnt
    // non-load flow of r5
    vecs[0]  = '{1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0,  0, 0,  1,  2,  0,  0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  5,  0, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  5, 0, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 0};
    // load r8 then consumer of rs=8: one stall, bubble in EX
    vecs[4]  = '{1, 2, 3, 1, 1, 8, 1, 1, 0, 0, 0,  0, 0,  2,  3,  0,  0, 0, 0, 0};
    vecs[5]  = '{1, 8, 6, 1, 0,10, 1, 0, 0, 0, 0,  1, 1,  0,  0,  8,  0, 1, 0, 1};
    vecs[6]  = '{1, 8, 6, 1, 0,10, 1, 0, 0, 0, 0,  0, 0,  8,  6,  0,  8, 0, 1, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 10,  0, 1, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 10, 0, 1, 1};
    // load to r0 then consumer of r0: no stall, $0 never advertised
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 1};
    vecs[10] = '{1, 0, 0, 1, 1,11, 1, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 11,  0, 1, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 11, 0, 1, 1};
    // flushed write to r9 must never reach MEM/WB
    vecs[13] = '{1, 1, 1, 0, 0, 9, 1, 0, 1, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 1};
    // load r7, load r12 (rt=7 but unused), consumer of rt=12 stalls
    vecs[16] = '{1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 1};
    vecs[17] = '{1, 1, 7, 1, 0,12, 1, 1, 0, 0, 0,  0, 0,  1,  7,  7,  0, 1, 0, 1};
    vecs[18] = '{1, 3,12, 0, 1,13, 1, 0, 0, 0, 0,  1, 1,  0,  0, 12,  7, 1, 1, 2};
    vecs[19] = '{1, 3,12, 0, 1,13, 1, 0, 0, 0, 0,  0, 0,  3, 12,  0, 12, 0, 1, 2};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 13,  0, 1, 0, 2};
    vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 13, 0, 1, 2};
    vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 2};

    // reset: outputs must be zero while held and for three idle edges after release
    rst_n = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chkComb("rst", 0, 0);
    chkRegs("rst", 0, 0, 0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;
    tick();
    tick();
    tick();
    chkComb("postrst", 0, 0);
    chkRegs("postrst", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      setIn(vecs[i].iv, vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].ut, vecs[i].rd,
            vecs[i].rw, vecs[i].mr, vecs[i].fl, vecs[i].bz, vecs[i].clr);
      #1;
      chkComb($sformatf("vec%0d", i), vecs[i].eStall, vecs[i].eBub);
      tick();
      chkRegs($sformatf("vec%0d", i), vecs[i].eRsEX, vecs[i].eRtEX, vecs[i].eRdMEM,
              vecs[i].eRdWB, vecs[i].eWM, vecs[i].eWW, vecs[i].eCnt);
    end

    // exBusy for 3 cycles with a load r14 (rs3, rt4) in EX and its consumer in ID
    setIn(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    tick();
    setIn(1, 3, 4, 1, 1, 14, 1, 1, 0, 0, 1);
    tick();
    chkRegs("busySetup", 3, 4, 6, 0, 1, 0, 0);
    setIn(1, 14, 0, 1, 0, 15, 1, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chkComb($sformatf("busy%0d", k), 1, 0);
      tick();
      chkRegs($sformatf("busy%0d", k), 3, 4, 0, (k == 0) ? 6 : 0, 0, (k == 0) ? 1 : 0, k + 1);
    end
    bus.exBusy = 1'b0;
    #1;
    chkComb("busyEndLoadUse", 1, 1);
    tick();
    chkRegs("busyEndLoadUse", 0, 0, 14, 0, 1, 0, 4);
    #1;
    chkComb("consumerIssue", 0, 0);
    tick();
    chkRegs("consumerIssue", 14, 0, 0, 14, 0, 1, 4);
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // async reset asserted in the second busy cycle
    setIn(1, 3, 4, 1, 1, 14, 1, 0, 0, 0, 0);
    tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    chkRegs("preRst", 3, 4, 0, 0, 0, 0, 5);
    #2;
    rst_n = 1'b0;
    bus.exBusy = 1'b0;
    #1;
    chkComb("midRst", 0, 0);
    chkRegs("midRst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chkRegs("afterMidRst", 0, 0, 0, 0, 0, 0, 0);

    // sustained stall saturates the counter; clear wins even while stalling
    bus.exBusy = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    chk("satReach", 32'(bus.stallCycles), 15);
    for (int k = 0; k < 5; k++) tick();
    chk("satHold", 32'(bus.stallCycles), 15);
    bus.statClear = 1'b1;
    tick();
    chk("clearWhileStall", 32'(bus.stallCycles), 0);
    bus.statClear = 1'b0;
    tick();
    chk("countAfterClear", 32'(bus.stallCycles), 1);
    bus.exBusy = 1'b0;
    tick();
    chk("idleNoCount", 32'(bus.stallCycles), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
